alu_core: RTL and testbench
===========================

ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 Parameter DATA_W, default 8, operand and result width; only 8 is supported because trigger constants are 8-bit.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 alu_rst_n  input  1  asynchronous, active-low reset.
REQ-004 alu_enable  input  1  global enable; 0 = idle, output and IRQ hold.
REQ-005 alu_enable_a  input  1  selects mode A when alu_enable=1.
REQ-006 alu_enable_b  input  1  selects mode B when alu_enable=1.
REQ-007 alu_op_a  input  2 (opcode_t)  mode A operation.
REQ-008 alu_op_b  input  2 (opcode_t)  mode B operation.
REQ-009 alu_in_a  input  8 (data_t)  operand A.
REQ-010 alu_in_b  input  8 (data_t)  operand B.
REQ-011 alu_irq_clr  input  1  level clear of alu_irq.
REQ-012 alu_out  output  8  registered result.
REQ-013 alu_irq  output  1  sticky interrupt.

Function
REQ-014 Mode A is active when alu_enable=1, alu_enable_a=1 and alu_enable_b=0; mode B is active when alu_enable=1, alu_enable_b=1 and alu_enable_a=0.
REQ-015 Mode A ops: 00 AND, 01 NAND, 10 OR, 11 XOR of alu_in_a and alu_in_b.
REQ-016 Mode B ops: 00 NAND, 01 AND, 10 XNOR, 11 OR of alu_in_a and alu_in_b.
REQ-017 In an active mode, alu_out loads the result at the clock edge sampling the inputs, so the latency is 1 cycle and a new result can be produced every cycle.
REQ-018 Idle means alu_enable=0, or alu_enable=1 with both mode enables at 0; idle holds alu_out and alu_irq unchanged.
REQ-019 alu_enable=1 with both mode enables at 1 is illegal and is treated as idle for alu_out.
REQ-020 Mode A IRQ triggers: AND result FF, NAND result 00, OR result F8, XOR result 83.
REQ-021 Mode B IRQ triggers: NAND result FF, AND result F4, XNOR result F1, OR result F5.
REQ-022 A trigger compares the newly computed result for the current op, so alu_irq rises in the same cycle alu_out shows the trigger value.
REQ-023 alu_irq is sticky and stays 1 across further results, triggering or not, until cleared.
REQ-024 When alu_irq_clr=1 is sampled, alu_irq is 0 from the next cycle.
REQ-025 If alu_irq_clr and a trigger occur in the same cycle, the clear wins: alu_irq=0, and the trigger event is dropped.
REQ-026 alu_irq_clr has no effect on alu_out.

Reset
REQ-027 While alu_rst_n=0, alu_out=00 and alu_irq=0 immediately, without waiting for a clock edge, including when reset is asserted mid-operation.
REQ-028 On the first rising edge after alu_rst_n deasserts, normal operation resumes; there is no extra wait cycle.

Configuration
REQ-029 With macro ALU_ERR_FLAG_EN defined, the block adds output alu_err (1 bit) to the interface.
REQ-030 With ALU_ERR_FLAG_EN defined, alu_err is set on the cycle after an illegal mode is sampled.
REQ-031 With ALU_ERR_FLAG_EN defined, alu_err is sticky and is cleared by alu_irq_clr, with the clear winning over a simultaneous set.
REQ-032 With ALU_ERR_FLAG_EN defined, alu_rst_n resets alu_err to 0.
REQ-033 Without ALU_ERR_FLAG_EN, the alu_err port and its logic are absent and illegal mode is plain idle.

Structure
REQ-034 alu_pkg holds: data_t (logic [7:0]), opcode_t (2-bit enum), mode_t (packed {enable_b, enable_a, enable}), and the eight IRQ trigger constants.
REQ-035 Sub-module alu_irq_ctrl holds the trigger compare and the sticky set/clear logic for alu_irq, plus alu_err when ALU_ERR_FLAG_EN is defined; alu_core holds the datapath and mode decode.

Verification
REQ-036 Reset: drive alu_rst_n=0 mid-operation with alu_out=5A -> alu_out=00 and alu_irq=0 before the next edge.
REQ-037 Mode A XOR: in_a=F0, in_b=73 -> alu_out=83 one cycle later and alu_irq=1; then XOR of 01,01 -> alu_out=00 with alu_irq still 1.
REQ-038 Mode B OR: in_a=F0, in_b=05 -> alu_out=F5 and alu_irq=1; then alu_irq_clr=1 for one cycle -> alu_irq=0 on the next cycle.
REQ-039 Same-cycle clear: alu_irq_clr=1 in the cycle of mode A AND with FF,FF -> alu_out=FF and alu_irq=0.
REQ-040 Idle: alu_enable=0 with changing operands for 5 cycles -> alu_out stays at its last value and alu_irq is unchanged.
REQ-041 Illegal mode: all three enables at 1 -> alu_out held; with ALU_ERR_FLAG_EN defined, alu_err=1 next cycle and is cleared by alu_irq_clr.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types, IRQ trigger constants and datapath helpers for the ALU core.
package alu_pkg;

  typedef logic [7:0] data_t;

  typedef enum logic [1:0] {
    OPC_00 = 2'b00,
    OPC_01 = 2'b01,
    OPC_10 = 2'b10,
    OPC_11 = 2'b11
  } opcode_t;

  typedef struct packed {
    logic enable_b;
    logic enable_a;
    logic enable;
  } mode_t;

  localparam data_t TRIG_A_AND  = 8'hFF;
  localparam data_t TRIG_A_NAND = 8'h00;
  localparam data_t TRIG_A_OR   = 8'hF8;
  localparam data_t TRIG_A_XOR  = 8'h83;
  localparam data_t TRIG_B_NAND = 8'hFF;
  localparam data_t TRIG_B_AND  = 8'hF4;
  localparam data_t TRIG_B_XNOR = 8'hF1;
  localparam data_t TRIG_B_OR   = 8'hF5;

  // Opcode meaning differs between mode A and mode B.
  function automatic data_t alu_compute(input logic mode_b, input opcode_t op,
                                        input data_t a, input data_t b);
    data_t r;
    r = 8'h00;
    if (mode_b) begin
      case (op)
        OPC_00:  r = ~(a & b);
        OPC_01:  r = a & b;
        OPC_10:  r = ~(a ^ b);
        OPC_11:  r = a | b;
        default: r = 8'h00;
      endcase
    end else begin
      case (op)
        OPC_00:  r = a & b;
        OPC_01:  r = ~(a & b);
        OPC_10:  r = a | b;
        OPC_11:  r = a ^ b;
        default: r = 8'h00;
      endcase
    end
    return r;
  endfunction

  function automatic data_t alu_trigger(input logic mode_b, input opcode_t op);
    data_t t;
    t = 8'h00;
    if (mode_b) begin
      case (op)
        OPC_00:  t = TRIG_B_NAND;
        OPC_01:  t = TRIG_B_AND;
        OPC_10:  t = TRIG_B_XNOR;
        OPC_11:  t = TRIG_B_OR;
        default: t = 8'h00;
      endcase
    end else begin
      case (op)
        OPC_00:  t = TRIG_A_AND;
        OPC_01:  t = TRIG_A_NAND;
        OPC_10:  t = TRIG_A_OR;
        OPC_11:  t = TRIG_A_XOR;
        default: t = 8'h00;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/alu_irq_ctrl.sv
// Trigger compare and sticky IRQ; with ALU_ERR_FLAG_EN defined also the sticky
// illegal-mode error flag. Clear always wins over a same-cycle set.
module alu_irq_ctrl
  import alu_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    active,
  input  logic    mode_b,
  input  opcode_t op,
  input  data_t   result,
  input  logic    irq_clr,
`ifdef ALU_ERR_FLAG_EN
  input  logic    illegal,
  output logic    err,
`endif
  output logic    irq
);

  logic trigger_s;
  logic irq_r;

  // Compare against the result being loaded this edge so irq rises alongside alu_out.
  always_comb begin
    trigger_s = 1'b0;
    if (active) begin
      trigger_s = (result == alu_trigger(mode_b, op));
    end else begin
      trigger_s = 1'b0;
    end
  end

  // Sticky interrupt, clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_r <= 1'b0;
    end else if (irq_clr) begin
      irq_r <= 1'b0;
    end else if (trigger_s) begin
      irq_r <= 1'b1;
    end else begin
      irq_r <= irq_r;
    end
  end

  assign irq = irq_r;

`ifdef ALU_ERR_FLAG_EN
  logic err_r;

  // Sticky illegal-mode flag sharing the irq clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (irq_clr) begin
      err_r <= 1'b0;
    end else if (illegal) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`endif

endmodule

// File: rtl/alu_core.sv
// Two-mode 8-bit logic ALU with registered result and sticky IRQ.
// Optional illegal-mode error output enabled by defining ALU_ERR_FLAG_EN.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              alu_rst_n,
  input  logic              alu_enable,
  input  logic              alu_enable_a,
  input  logic              alu_enable_b,
  input  opcode_t           alu_op_a,
  input  opcode_t           alu_op_b,
  input  logic [DATA_W-1:0] alu_in_a,
  input  logic [DATA_W-1:0] alu_in_b,
  input  logic              alu_irq_clr,
`ifdef ALU_ERR_FLAG_EN
  output logic              alu_err,
`endif
  output logic [DATA_W-1:0] alu_out,
  output logic              alu_irq
);

  mode_t   mode_s;
  logic    mode_a_s;
  logic    mode_b_s;
  logic    active_s;
  opcode_t op_s;
  data_t   result_s;
  data_t   out_r;

  assign mode_s = '{enable_b: alu_enable_b, enable_a: alu_enable_a, enable: alu_enable};

  // Mode decode; both mode enables set counts as idle for the datapath.
  always_comb begin
    mode_a_s = mode_s.enable & mode_s.enable_a & ~mode_s.enable_b;
    mode_b_s = mode_s.enable & mode_s.enable_b & ~mode_s.enable_a;
    active_s = mode_a_s | mode_b_s;
    if (mode_b_s) begin
      op_s = alu_op_b;
    end else begin
      op_s = alu_op_a;
    end
    result_s = alu_compute(mode_b_s, op_s, data_t'(alu_in_a), data_t'(alu_in_b));
  end

  // Result register, held while idle.
  always_ff @(posedge clk or negedge alu_rst_n) begin
    if (!alu_rst_n) begin
      out_r <= 8'h00;
    end else if (active_s) begin
      out_r <= result_s;
    end else begin
      out_r <= out_r;
    end
  end

  assign alu_out = DATA_W'(out_r);

`ifdef ALU_ERR_FLAG_EN
  logic illegal_s;
  assign illegal_s = mode_s.enable & mode_s.enable_a & mode_s.enable_b;
`endif

  alu_irq_ctrl u_irq_ctrl (
    .clk     (clk),
    .rst_n   (alu_rst_n),
    .active  (active_s),
    .mode_b  (mode_b_s),
    .op      (op_s),
    .result  (result_s),
    .irq_clr (alu_irq_clr),
`ifdef ALU_ERR_FLAG_EN
    .illegal (illegal_s),
    .err     (alu_err),
`endif
    .irq     (alu_irq)
  );

endmodule

// File: tb/tb_alu_core.sv
// Directed self-checking bench for alu_core; covers alu_err when ALU_ERR_FLAG_EN is defined.
module tb_alu_core;
  import alu_pkg::*;

  logic    clk;
  logic    alu_rst_n;
  logic    alu_enable;
  logic    alu_enable_a;
  logic    alu_enable_b;
  opcode_t alu_op_a;
  opcode_t alu_op_b;
  logic [7:0] alu_in_a;
  logic [7:0] alu_in_b;
  logic    alu_irq_clr;
  logic [7:0] alu_out;
  logic    alu_irq;
`ifdef ALU_ERR_FLAG_EN
  logic    alu_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_core #(.DATA_W(8)) dut (
    .clk          (clk),
    .alu_rst_n    (alu_rst_n),
    .alu_enable   (alu_enable),
    .alu_enable_a (alu_enable_a),
    .alu_enable_b (alu_enable_b),
    .alu_op_a     (alu_op_a),
    .alu_op_b     (alu_op_b),
    .alu_in_a     (alu_in_a),
    .alu_in_b     (alu_in_b),
    .alu_irq_clr  (alu_irq_clr),
`ifdef ALU_ERR_FLAG_EN
    .alu_err      (alu_err),
`endif
    .alu_out      (alu_out),
    .alu_irq      (alu_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       mb;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic       irq;
  } vec_t;

  // Hand-computed results; irq column is whether the op's trigger value is hit.
  vec_t vecs [17] = '{
    {1'b0, 2'd0, 8'hF0, 8'h3C, 8'h30, 1'b0},
    {1'b0, 2'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1},
    {1'b0, 2'd0, 8'hF4, 8'hFF, 8'hF4, 1'b0},
    {1'b0, 2'd1, 8'h0F, 8'hF0, 8'hFF, 1'b0},
    {1'b0, 2'd1, 8'hFF, 8'hFF, 8'h00, 1'b1},
    {1'b0, 2'd2, 8'h0F, 8'h30, 8'h3F, 1'b0},
    {1'b0, 2'd2, 8'hF0, 8'h08, 8'hF8, 1'b1},
    {1'b0, 2'd3, 8'hA5, 8'h5A, 8'hFF, 1'b0},
    {1'b0, 2'd3, 8'hF0, 8'h73, 8'h83, 1'b1},
    {1'b1, 2'd0, 8'hFF, 8'hFF, 8'h00, 1'b0},
    {1'b1, 2'd0, 8'h00, 8'h00, 8'hFF, 1'b1},
    {1'b1, 2'd1, 8'hF0, 8'h3C, 8'h30, 1'b0},
    {1'b1, 2'd1, 8'hF4, 8'hFF, 8'hF4, 1'b1},
    {1'b1, 2'd2, 8'hA5, 8'h5A, 8'h00, 1'b0},
    {1'b1, 2'd2, 8'h0F, 8'h01, 8'hF1, 1'b1},
    {1'b1, 2'd3, 8'h0F, 8'h30, 8'h3F, 1'b0},
    {1'b1, 2'd3, 8'hF0, 8'h05, 8'hF5, 1'b1}
  };

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic ea, input logic eb, input logic [1:0] op,
                       input logic [7:0] a, input logic [7:0] b, input logic clr);
    alu_enable   = en;
    alu_enable_a = ea;
    alu_enable_b = eb;
    alu_op_a     = opcode_t'(op);
    alu_op_b     = opcode_t'(op);
    alu_in_a     = a;
    alu_in_b     = b;
    alu_irq_clr  = clr;
  endtask

  initial begin
    alu_rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
    #1;
    check("reset_out", 32'(alu_out), 32'h00);
    check("reset_irq", 32'(alu_irq), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    alu_rst_n = 1'b1;

    // Mode A XOR trigger, then a non-trigger result keeps irq sticky.
    drive(1'b1, 1'b1, 1'b0, 2'd3, 8'hF0, 8'h73, 1'b0);
    step();
    check("xor_out", 32'(alu_out), 32'h83);
    check("xor_irq", 32'(alu_irq), 32'h1);
    drive(1'b1, 1'b1, 1'b0, 2'd3, 8'h01, 8'h01, 1'b0);
    step();
    check("xor2_out", 32'(alu_out), 32'h00);
    check("xor2_irq_sticky", 32'(alu_irq), 32'h1);

    // Mode B OR trigger, then a one-cycle clear that must not touch alu_out.
    drive(1'b1, 1'b0, 1'b1, 2'd3, 8'hF0, 8'h05, 1'b0);
    step();
    check("bor_out", 32'(alu_out), 32'hF5);
    check("bor_irq", 32'(alu_irq), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1);
    step();
    check("clr_irq", 32'(alu_irq), 32'h0);
    check("clr_out_held", 32'(alu_out), 32'hF5);

    // Clear and trigger in the same cycle: clear wins, event dropped.
    drive(1'b1, 1'b1, 1'b0, 2'd0, 8'hFF, 8'hFF, 1'b1);
    step();
    check("same_clr_out", 32'(alu_out), 32'hFF);
    check("same_clr_irq", 32'(alu_irq), 32'h0);
    drive(1'b1, 1'b1, 1'b0, 2'd0, 8'h0F, 8'hF0, 1'b0);
    step();
    check("dropped_trig_irq", 32'(alu_irq), 32'h0);

    // Every op of both modes, trigger and non-trigger operands.
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1);
      step();
      check("vec_pre_clr", 32'(alu_irq), 32'h0);
      drive(1'b1, ~vecs[i].mb, vecs[i].mb, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      step();
      check($sformatf("vec%0d_out", i), 32'(alu_out), 32'(vecs[i].out));
      check($sformatf("vec%0d_irq", i), 32'(alu_irq), 32'(vecs[i].irq));
    end

    // Idle with changing trigger-capable operands: out F5 and irq 1 hold.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, i[0], ~i[0], i[1:0], 8'(i * 37), 8'hFF, 1'b0);
      step();
      check("idle_out", 32'(alu_out), 32'hF5);
      check("idle_irq", 32'(alu_irq), 32'h1);
    end
    drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h12, 8'h34, 1'b0);
    step();
    check("idle_noen_out", 32'(alu_out), 32'hF5);

    // Illegal mode: datapath idle, irq untouched even with trigger operands.
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1);
    step();
    drive(1'b1, 1'b1, 1'b1, 2'd0, 8'hFF, 8'hFF, 1'b0);
    step();
    check("illegal_out", 32'(alu_out), 32'hF5);
    check("illegal_irq", 32'(alu_irq), 32'h0);
`ifdef ALU_ERR_FLAG_EN
    check("err_set", 32'(alu_err), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
    step();
    check("err_sticky", 32'(alu_err), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1);
    step();
    check("err_clr", 32'(alu_err), 32'h0);
    drive(1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 8'h00, 1'b1);
    step();
    check("err_clr_wins", 32'(alu_err), 32'h0);
`endif

    // Reset mid-operation with out=5A and irq set.
    drive(1'b1, 1'b1, 1'b0, 2'd3, 8'hF0, 8'h73, 1'b0);
    step();
    drive(1'b1, 1'b1, 1'b0, 2'd2, 8'h50, 8'h0A, 1'b0);
    step();
    check("pre_rst_out", 32'(alu_out), 32'h5A);
    check("pre_rst_irq", 32'(alu_irq), 32'h1);
    alu_rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'(alu_out), 32'h00);
    check("async_rst_irq", 32'(alu_irq), 32'h0);
`ifdef ALU_ERR_FLAG_EN
    check("async_rst_err", 32'(alu_err), 32'h0);
`endif
    #2;
    alu_rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 2'd3, 8'hF0, 8'h73, 1'b0);
    step();
    check("post_rst_out", 32'(alu_out), 32'h83);
    check("post_rst_irq", 32'(alu_irq), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
